// File: rtl/add_preamble_if.sv
// Byte-stream bundle between the CRC stage, add_preamble and the PHY byte interface.
// ADD_PREAMBLE_STATS_EN adds the frames_sent / frames_dropped counters to the bundle.
// Stream semantics: there is no backpressure. A byte slot exists only on clocks where
// data_enable_* is high. data_valid_* qualifies data_* on those slots and is ignored otherwise.
interface add_preamble_if;
    logic [7:0] data_in;
    logic       data_valid_in;
    logic       data_enable_in;
    logic [7:0] data_out;
    logic       data_valid_out;
    logic       data_enable_out;
    logic       frame_drop;
    logic       dbg_pre_busy;
    logic [3:0] dbg_pre_cnt;
`ifdef ADD_PREAMBLE_STATS_EN
    logic [15:0] frames_sent;
    logic [15:0] frames_dropped;
`endif

    modport master (
`ifdef ADD_PREAMBLE_STATS_EN
        input  frames_sent,
        input  frames_dropped,
`endif
        output data_in,
        output data_valid_in,
        output data_enable_in,
        input  data_out,
        input  data_valid_out,
        input  data_enable_out,
        input  frame_drop,
        input  dbg_pre_busy,
        input  dbg_pre_cnt
    );

    modport slave (
`ifdef ADD_PREAMBLE_STATS_EN
        output frames_sent,
        output frames_dropped,
`endif
        input  data_in,
        input  data_valid_in,
        input  data_enable_in,
        output data_out,
        output data_valid_out,
        output data_enable_out,
        output frame_drop,
        output dbg_pre_busy,
        output dbg_pre_cnt
    );
endinterface

// File: rtl/add_preamble.sv
// add_preamble: delays the frame stream by 8 byte slots, prepends 7 x 0x55 + 0xD5 and drops
// frames that start inside the inter-frame gap. Optional counters: ADD_PREAMBLE_STATS_EN.
module add_preamble #(
    parameter int IFG_BYTES = 12,
    parameter int GAP_CNT_W = 6
) (
    input logic           clk,
    input logic           rst_n,
    add_preamble_if.slave bus
);
    localparam logic [GAP_CNT_W-1:0] GAP_MIN  = GAP_CNT_W'(IFG_BYTES + 8);
    localparam logic [GAP_CNT_W-1:0] GAP_MAX  = '1;
    localparam logic [7:0]           PRE_BYTE = 8'h55;
    localparam logic [7:0]           SFD_BYTE = 8'hD5;
    localparam logic [3:0]           SFD_SLOT = 4'd7;

    typedef enum logic {ST_IDLE, ST_PREAMBLE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           pre_cnt_q, pre_cnt_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic                 prev_valid_q, prev_valid_d;
    logic                 drop_q, drop_d;
    logic [7:0][8:0]      dline_q, dline_d;
    logic [7:0]           data_out_q, data_out_d;
    logic                 data_valid_out_q, data_valid_out_d;
    logic                 data_enable_out_q;
    logic                 frame_drop_q, frame_drop_d;
    logic                 frame_start, accept, reject, sfd_emit;

    always_comb begin
        state_d          = state_q;
        pre_cnt_d        = pre_cnt_q;
        gap_cnt_d        = gap_cnt_q;
        prev_valid_d     = prev_valid_q;
        drop_d           = drop_q;
        dline_d          = dline_q;
        data_out_d       = data_out_q;
        data_valid_out_d = data_valid_out_q;
        frame_drop_d     = 1'b0;
        sfd_emit         = 1'b0;
        frame_start      = bus.data_valid_in && !prev_valid_q;
        accept           = frame_start && (gap_cnt_q >= GAP_MIN);
        reject           = frame_start && !accept;

        if (bus.data_enable_in) begin
            prev_valid_d = bus.data_valid_in;
            frame_drop_d = reject;
            if (bus.data_valid_in)
                gap_cnt_d = '0;
            else if (gap_cnt_q != GAP_MAX)
                gap_cnt_d = gap_cnt_q + 1'b1;

            if (!bus.data_valid_in)
                drop_d = 1'b0;
            else if (reject)
                drop_d = 1'b1;

            // Bytes of a rejected frame still occupy their slot, but enter as invalid.
            dline_d = {dline_q[6:0], {bus.data_valid_in && !(drop_q || reject), bus.data_in}};

            if (state_q == ST_PREAMBLE) begin
                data_valid_out_d = 1'b1;
                if (pre_cnt_q == SFD_SLOT) begin
                    data_out_d = SFD_BYTE;
                    sfd_emit   = 1'b1;
                    state_d    = ST_IDLE;
                    pre_cnt_d  = 4'd0;
                end else begin
                    data_out_d = PRE_BYTE;
                    pre_cnt_d  = pre_cnt_q + 4'd1;
                end
            end else if (accept) begin
                data_valid_out_d = 1'b1;
                data_out_d       = PRE_BYTE;
                state_d          = ST_PREAMBLE;
                pre_cnt_d        = 4'd1;
            end else begin
                data_valid_out_d = dline_q[7][8];
                data_out_d       = dline_q[7][8] ? dline_q[7][7:0] : 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            pre_cnt_q         <= 4'd0;
            gap_cnt_q         <= GAP_MAX;
            prev_valid_q      <= 1'b0;
            drop_q            <= 1'b0;
            dline_q           <= '0;
            data_out_q        <= 8'h00;
            data_valid_out_q  <= 1'b0;
            data_enable_out_q <= 1'b0;
            frame_drop_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            pre_cnt_q         <= pre_cnt_d;
            gap_cnt_q         <= gap_cnt_d;
            prev_valid_q      <= prev_valid_d;
            drop_q            <= drop_d;
            dline_q           <= dline_d;
            data_out_q        <= data_out_d;
            data_valid_out_q  <= data_valid_out_d;
            data_enable_out_q <= bus.data_enable_in;
            frame_drop_q      <= frame_drop_d;
        end
    end

    assign bus.data_out        = data_out_q;
    assign bus.data_valid_out  = data_valid_out_q;
    assign bus.data_enable_out = data_enable_out_q;
    assign bus.frame_drop      = frame_drop_q;
    assign bus.dbg_pre_busy    = (state_q == ST_PREAMBLE);
    assign bus.dbg_pre_cnt     = pre_cnt_q;

`ifdef ADD_PREAMBLE_STATS_EN
    logic [15:0] frames_sent_q, frames_sent_d;
    logic [15:0] frames_dropped_q, frames_dropped_d;

    always_comb begin
        frames_sent_d    = frames_sent_q + {15'd0, sfd_emit};
        frames_dropped_d = frames_dropped_q + {15'd0, frame_drop_d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames_sent_q    <= 16'd0;
            frames_dropped_q <= 16'd0;
        end else begin
            frames_sent_q    <= frames_sent_d;
            frames_dropped_q <= frames_dropped_d;
        end
    end

    assign bus.frames_sent    = frames_sent_q;
    assign bus.frames_dropped = frames_dropped_q;
`endif
endmodule
